tag_store: RTL and testbench

TAG_STORE -- requirements
Module: tag_store

---
 rtl/tag_store_pkg.sv | 24 ++
 rtl/tag_store_plru.sv | 46 ++++
 rtl/tag_store.sv | 174 +++++++++++++++++
 tb/tb_tag_store.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tag_store_pkg.sv
// Shared sizing helpers for the set-associative tag store and its PLRU tree.
package tag_store_pkg;

    localparam int MAX_WAYS = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Way indices stay at least one bit wide so a direct-mapped store still has a port.
    function automatic int way_w(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

    function automatic int plru_w(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/tag_store_plru.sv
// Combinational tree-PLRU: victim walk and most-recently-used update for one set.
module plru_tree
    import tag_store_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [plru_w(WAYS)-1:0] plru_i,
    input  logic [way_w(WAYS)-1:0]  access_way_i,
    output logic [plru_w(WAYS)-1:0] plru_o,
    output logic [way_w(WAYS)-1:0]  victim_o
);
    localparam int PW     = plru_w(WAYS);
    localparam int WW     = way_w(WAYS);
    localparam int LEVELS = (WAYS > 1) ? clog2(WAYS) : 0;

    // Node n has children 2n+1 / 2n+2; a set bit steers the victim walk right.
    always_comb begin : victim_walk
        int            node;
        logic [PW-1:0] bits;
        node = 0;
        bits = '0;
        for (int l = 0; l < LEVELS; l++) begin
            bits = plru_i >> node;
            node = 2 * node + 1 + int'(bits[0]);
        end
        victim_o = WW'(node - (WAYS - 1));
    end

    always_comb begin : mru_update
        int            node;
        logic [WW-1:0] way;
        plru_o = plru_i;
        node   = 0;
        way    = '0;
        for (int l = 0; l < LEVELS; l++) begin
            way = access_way_i >> (LEVELS - 1 - l);
            if (way[0]) begin
                plru_o = plru_o & ~(PW'(1) << node);
            end else begin
                plru_o = plru_o | (PW'(1) << node);
            end
            node = 2 * node + 1 + int'(way[0]);
        end
    end

endmodule

// File: rtl/tag_store.sv
// Set-associative tag directory with lookup / allocate / deload and tree-PLRU replacement.
module tag_store
    import tag_store_pkg::*;
#(
    parameter int INDEX_LENGTH = 7,
    parameter int TAG_LENGTH   = 22,
    parameter int CACHE_LINES  = 32,
    parameter int WAYS         = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [INDEX_LENGTH-1:0] index_i,
    input  logic [TAG_LENGTH-1:0]   tag_i,
    input  logic                    lookup_i,
    input  logic                    alloc_i,
    input  logic                    deload_i,
    output logic                    hit_o,
    output logic [way_w(WAYS)-1:0]  hit_way_o,
    output logic [TAG_LENGTH-1:0]   tag_o,
    output logic                    free_o,
    output logic                    evict_o,
    output logic                    err_o
);
    localparam int WW = way_w(WAYS);
    localparam int PW = plru_w(WAYS);
    localparam int SW = (CACHE_LINES > 1) ? clog2(CACHE_LINES) : 1;

    logic [WAYS-1:0]       valid_q [CACHE_LINES];
    logic [PW-1:0]         plru_q  [CACHE_LINES];
    logic [TAG_LENGTH-1:0] tags_q  [CACHE_LINES][WAYS];

    logic                  hit_q, hit_d;
    logic [WW-1:0]         way_q, way_d;
    logic [TAG_LENGTH-1:0] tag_q, tag_d;
    logic                  free_q, free_d;
    logic                  evict_q, evict_d;
    logic                  err_q, err_d;

    logic [SW-1:0]         set_idx;
    logic                  legal, req, do_deload, do_alloc, do_lookup;
    logic [WAYS-1:0]       set_valid, match, valid_d;
    logic                  hit, full;
    logic [WW-1:0]         hit_way, free_way, victim_way, write_way, touch_way;
    logic [PW-1:0]         set_plru, plru_next;
    logic [TAG_LENGTH-1:0] hit_tag, victim_tag;
    logic                  tag_we, valid_we, plru_we;

    assign set_idx = index_i[SW-1:0];
    assign legal   = ({1'b0, index_i} < (INDEX_LENGTH + 1)'(CACHE_LINES));
    assign req     = lookup_i | alloc_i | deload_i;

    // Deload wins over alloc; a bare lookup only acts when nothing else is requested.
    assign do_deload = legal & deload_i;
    assign do_alloc  = legal & alloc_i & ~deload_i;
    assign do_lookup = legal & lookup_i & ~alloc_i & ~deload_i;

    always_comb begin : set_compare
        set_valid = valid_q[set_idx];
        set_plru  = plru_q[set_idx];
        match     = '0;
        hit_way   = '0;
        free_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = set_valid[w] && (tags_q[set_idx][w] == tag_i);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w])      hit_way  = WW'(w);
            if (!set_valid[w]) free_way = WW'(w);
        end
    end

    assign hit        = |match;
    assign full       = &set_valid;
    assign write_way  = full ? victim_way : free_way;
    assign touch_way  = hit ? hit_way : write_way;
    assign hit_tag    = tags_q[set_idx][hit_way];
    // Invalid entries hold stale tags, so a non-full set reports no victim tag.
    assign victim_tag = full ? tags_q[set_idx][victim_way] : '0;

    plru_tree #(
        .WAYS(WAYS)
    ) u_plru (
        .plru_i      (set_plru),
        .access_way_i(touch_way),
        .plru_o      (plru_next),
        .victim_o    (victim_way)
    );

    always_comb begin : next_state
        tag_we   = 1'b0;
        valid_we = 1'b0;
        plru_we  = 1'b0;
        valid_d  = set_valid;
        hit_d    = 1'b0;
        way_d    = way_q;
        tag_d    = tag_q;
        free_d   = free_q;
        evict_d  = 1'b0;
        err_d    = req & (~legal | (alloc_i & deload_i));
        if (req && !legal) begin
            way_d  = '0;
            tag_d  = '0;
            free_d = 1'b0;
        end else if (do_deload) begin
            hit_d  = hit;
            way_d  = hit ? hit_way : '0;
            tag_d  = hit ? hit_tag : victim_tag;
            free_d = ~full;
            if (hit) begin
                valid_we         = 1'b1;
                valid_d[hit_way] = 1'b0;
            end
        end else if (do_alloc) begin
            hit_d   = hit;
            free_d  = ~full;
            plru_we = 1'b1;
            if (hit) begin
                way_d = hit_way;
                tag_d = hit_tag;
            end else begin
                way_d              = write_way;
                tag_d              = victim_tag;
                evict_d            = full;
                tag_we             = 1'b1;
                valid_we           = 1'b1;
                valid_d[write_way] = 1'b1;
            end
        end else if (do_lookup) begin
            hit_d   = hit;
            way_d   = hit ? hit_way : '0;
            tag_d   = hit ? hit_tag : victim_tag;
            free_d  = ~full;
            plru_we = hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < CACHE_LINES; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            hit_q   <= 1'b0;
            way_q   <= '0;
            tag_q   <= '0;
            free_q  <= 1'b0;
            evict_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (valid_we) valid_q[set_idx] <= valid_d;
            if (plru_we)  plru_q[set_idx]  <= plru_next;
            hit_q   <= hit_d;
            way_q   <= way_d;
            tag_q   <= tag_d;
            free_q  <= free_d;
            evict_q <= evict_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_we && !rst_i) begin
            tags_q[set_idx][write_way] <= tag_i;
        end
    end

    assign hit_o     = hit_q;
    assign hit_way_o = way_q;
    assign tag_o     = tag_q;
    assign free_o    = free_q;
    assign evict_o   = evict_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_tag_store.sv
// Scenario bench for tag_store (WAYS=2, CACHE_LINES=32) with a queued expectation scoreboard.
module tb_tag_store;

    logic        clk = 1'b0;
    logic        rst_i, lookup_i, alloc_i, deload_i;
    logic [6:0]  index_i;
    logic [21:0] tag_i;
    logic        hit_o, hit_way_o, free_o, evict_o, err_o;
    logic [21:0] tag_o;
    logic [26:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [26:0] val;
        logic [26:0] care;
    } exp_t;

    typedef struct {
        logic        r, lk, al, dl;
        logic [6:0]  idx;
        logic [21:0] tg;
        exp_t        e;
    } step_t;

    exp_t sb[$];

    tag_store #(
        .INDEX_LENGTH(7),
        .TAG_LENGTH  (22),
        .CACHE_LINES (32),
        .WAYS        (2)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .index_i  (index_i),
        .tag_i    (tag_i),
        .lookup_i (lookup_i),
        .alloc_i  (alloc_i),
        .deload_i (deload_i),
        .hit_o    (hit_o),
        .hit_way_o(hit_way_o),
        .tag_o    (tag_o),
        .free_o   (free_o),
        .evict_o  (evict_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    assign obs = {hit_o, hit_way_o, tag_o, free_o, evict_o, err_o};

    // Stimulus plus expected outputs; wc/tc/fc select whether way, tag and free are checked.
    function automatic step_t st(string n, logic r, logic lk, logic al, logic dl,
                                 logic [6:0] idx, logic [21:0] tg,
                                 logic h, logic w, logic wc, logic [21:0] t, logic tc,
                                 logic f, logic fc, logic ev, logic er);
        step_t s;
        s.r = r; s.lk = lk; s.al = al; s.dl = dl; s.idx = idx; s.tg = tg;
        s.e.name = n;
        s.e.val  = {h, w, t, f, ev, er};
        s.e.care = {1'b1, wc, {22{tc}}, fc, 1'b1, 1'b1};
        return s;
    endfunction

    task automatic drive(input step_t s);
        rst_i = s.r; lookup_i = s.lk; alloc_i = s.al; deload_i = s.dl;
        index_i = s.idx; tag_i = s.tg;
        sb.push_back(s.e);
        @(negedge clk);
        rst_i = 1'b0; lookup_i = 1'b0; alloc_i = 1'b0; deload_i = 1'b0;
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        s.push_back(st("rst_hold", 1,1,1,0, 5, 22'h3,   0,0,1, 22'h0,1, 0,1, 0,0));
        s.push_back(st("rst_idle", 0,0,0,0, 0, 22'h0,   0,0,1, 22'h0,1, 0,1, 0,0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sb.pop_front();
            n_checks++;
            if (((obs ^ e.val) & e.care) !== 27'd0) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h care %h", e.name, obs, e.val, e.care);
            end
        end
    endtask

    task automatic test_lookup_empty();
        step_t s[$];
        exp_t  e;
        s.push_back(st("lk_empty", 0,1,0,0, 5, 22'h1234, 0,0,0, 22'h0,0, 1,1, 0,0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sb.pop_front();
            n_checks++;
            if (((obs ^ e.val) & e.care) !== 27'd0) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h care %h", e.name, obs, e.val, e.care);
            end
        end
    endtask

    task automatic test_alloc_fill();
        step_t s[$];
        exp_t  e;
        s.push_back(st("alloc_A",  0,0,1,0, 5, 22'hA, 0,0,1, 22'h0,0, 1,1, 0,0));
        s.push_back(st("alloc_B",  0,0,1,0, 5, 22'hB, 0,1,1, 22'h0,0, 1,1, 0,0));
        s.push_back(st("lk_B_hit", 0,1,0,0, 5, 22'hB, 1,1,1, 22'hB,1, 0,1, 0,0));
        s.push_back(st("lk_A_hit", 0,1,0,0, 5, 22'hA, 1,0,1, 22'hA,1, 0,1, 0,0));
        s.push_back(st("idle_hold",0,0,0,0, 0, 22'h0, 0,0,1, 22'hA,1, 0,1, 0,0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sb.pop_front();
            n_checks++;
            if (((obs ^ e.val) & e.care) !== 27'd0) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h care %h", e.name, obs, e.val, e.care);
            end
        end
    endtask

    task automatic test_evict();
        step_t s[$];
        exp_t  e;
        s.push_back(st("alloc_C_ev", 0,0,1,0, 5, 22'hC, 0,1,1, 22'hB,1, 0,1, 1,0));
        s.push_back(st("lk_B_miss",  0,1,0,0, 5, 22'hB, 0,0,0, 22'h0,0, 0,1, 0,0));
        s.push_back(st("lk_C_hit",   0,1,0,0, 5, 22'hC, 1,1,1, 22'hC,1, 0,1, 0,0));
        s.push_back(st("alloc_A_dup",0,0,1,0, 5, 22'hA, 1,0,1, 22'hA,1, 0,1, 0,0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sb.pop_front();
            n_checks++;
            if (((obs ^ e.val) & e.care) !== 27'd0) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h care %h", e.name, obs, e.val, e.care);
            end
        end
    endtask

    task automatic test_deload();
        step_t s[$];
        exp_t  e;
        s.push_back(st("deload_A",   0,0,0,1, 5, 22'hA,  1,0,1, 22'hA,1, 0,1, 0,0));
        s.push_back(st("lk_A_miss",  0,1,0,0, 5, 22'hA,  0,0,0, 22'h0,0, 1,1, 0,0));
        s.push_back(st("alloc_D",    0,0,1,0, 5, 22'hD,  0,0,1, 22'h0,0, 1,1, 0,0));
        s.push_back(st("lk_D_hit",   0,1,0,0, 5, 22'hD,  1,0,1, 22'hD,1, 0,1, 0,0));
        s.push_back(st("alloc_F_ev", 0,0,1,0, 5, 22'hF,  0,1,1, 22'hC,1, 0,1, 1,0));
        s.push_back(st("lk_D_again", 0,1,0,0, 5, 22'hD,  1,0,1, 22'hD,1, 0,1, 0,0));
        s.push_back(st("deload_miss",0,0,0,1, 5, 22'h99, 0,0,0, 22'h0,0, 0,1, 0,0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sb.pop_front();
            n_checks++;
            if (((obs ^ e.val) & e.care) !== 27'd0) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h care %h", e.name, obs, e.val, e.care);
            end
        end
    endtask

    task automatic test_errors();
        step_t s[$];
        exp_t  e;
        s.push_back(st("alloc_deload",0,0,1,1, 5,  22'hF,  1,1,1, 22'hF,1, 0,1, 0,1));
        s.push_back(st("err_pulse",   0,0,0,0, 0,  22'h0,  0,1,1, 22'hF,1, 0,1, 0,0));
        s.push_back(st("lk_F_gone",   0,1,0,0, 5,  22'hF,  0,0,0, 22'h0,0, 1,1, 0,0));
        s.push_back(st("lk_idx40",    0,1,0,0, 40, 22'hD,  0,0,0, 22'h0,0, 0,0, 0,1));
        s.push_back(st("alloc_idx40", 0,0,1,0, 40, 22'h77, 0,0,0, 22'h0,0, 0,0, 0,1));
        s.push_back(st("deload_idx40",0,0,0,1, 40, 22'hD,  0,0,0, 22'h0,0, 0,0, 0,1));
        s.push_back(st("lk_D_kept",   0,1,0,0, 5,  22'hD,  1,0,1, 22'hD,1, 1,1, 0,0));
        s.push_back(st("lk_idx8_77",  0,1,0,0, 8,  22'h77, 0,0,0, 22'h0,0, 1,1, 0,0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sb.pop_front();
            n_checks++;
            if (((obs ^ e.val) & e.care) !== 27'd0) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h care %h", e.name, obs, e.val, e.care);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        exp_t  e;
        s.push_back(st("rst_w_alloc", 1,0,1,0, 5, 22'h55, 0,0,1, 22'h0,1, 0,1, 0,0));
        s.push_back(st("lk_D_cleared",0,1,0,0, 5, 22'hD,  0,0,0, 22'h0,0, 0,0, 0,0));
        s.push_back(st("lk_55_absent",0,1,0,0, 5, 22'h55, 0,0,0, 22'h0,0, 0,0, 0,0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sb.pop_front();
            n_checks++;
            if (((obs ^ e.val) & e.care) !== 27'd0) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h care %h", e.name, obs, e.val, e.care);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; lookup_i = 1'b0; alloc_i = 1'b0; deload_i = 1'b0;
        index_i = '0; tag_i = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_lookup_empty();
        test_alloc_fill();
        test_evict();
        test_deload();
        test_errors();
        test_reset_mid();
        n_checks++;
        if (sb.size() !== 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
